// File: rtl/dds_sweep_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : dds_sweep_ctl
//  Description : Frequency-sweep sequencer that steps the DDS frequency word
//                from a start to a stop value with a programmable dwell.
//  Revision    : 1.0 - initial release
// ============================================================================
module dds_sweep_ctl #(
    parameter int FW  = 12,
    parameter int DWW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [FW-1:0]  cfg_start,
    input  logic [FW-1:0]  cfg_stop,
    input  logic [FW-1:0]  cfg_step,
    input  logic [DWW-1:0] cfg_dwell,
    input  logic [1:0]     cfg_mode,
    output logic           cfg_err,
    input  logic           start,
    input  logic           abort,
    output logic [FW-1:0]  freq_ctl,
    output logic           busy,
    output logic           step_tick,
    output logic           done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DWELL = 2'd1;
    localparam logic [1:0] c_ST_ADV   = 2'd2;
    localparam logic [1:0] c_ST_FIN   = 2'd3;

    localparam logic [1:0] c_MODE_SINGLE = 2'd0;
    localparam logic [1:0] c_MODE_REPEAT = 2'd1;
    localparam logic [1:0] c_MODE_TRI    = 2'd2;
    localparam logic [1:0] c_MODE_RSVD   = 2'd3;

    localparam logic [FW-1:0] c_STEP_ONE = FW'(1);

    logic [1:0]     r_state;
    logic [FW-1:0]  r_freq;
    logic           r_dir_up;
    logic [DWW-1:0] r_cnt;
    logic           r_busy;
    logic           r_step_tick;
    logic           r_done;
    logic           r_cfg_err;

    logic [FW-1:0]  r_cfg_start;
    logic [FW-1:0]  r_cfg_stop;
    logic [FW-1:0]  r_cfg_step;
    logic [DWW-1:0] r_cfg_dwell;
    logic [1:0]     r_cfg_mode;

    logic [1:0]     w_state_nxt;
    logic [FW-1:0]  w_freq_nxt;
    logic           w_dir_nxt;
    logic [DWW-1:0] w_cnt_nxt;
    logic           w_busy_nxt;
    logic           w_tick_nxt;
    logic           w_done_nxt;

    logic           w_xfer;
    logic           w_cfg_bad;
    logic           w_cfg_take;
    logic [FW-1:0]  w_eff_start;
    logic [FW:0]    w_sum;
    logic [FW:0]    w_diff;
    logic [FW-1:0]  w_up_val;
    logic [FW-1:0]  w_dn_val;

    assign cfg_ready = (r_state == c_ST_IDLE);
    assign cfg_err   = r_cfg_err;
    assign freq_ctl  = r_freq;
    assign busy      = r_busy;
    assign step_tick = r_step_tick;
    assign done      = r_done;

    assign w_xfer      = cfg_valid && cfg_ready;
    assign w_cfg_bad   = (cfg_start > cfg_stop) || (cfg_mode == c_MODE_RSVD);
    assign w_cfg_take  = w_xfer && !w_cfg_bad;
    // A start arriving alongside an accepted config sweeps with the new values
    assign w_eff_start = w_cfg_take ? cfg_start : r_cfg_start;

    // One extra bit keeps the top-of-range sum and the below-zero difference exact
    assign w_sum    = {1'b0, r_freq} + {1'b0, r_cfg_step};
    assign w_diff   = {1'b0, r_freq} - {1'b0, r_cfg_step};
    assign w_up_val = (w_sum > {1'b0, r_cfg_stop}) ? r_cfg_stop : w_sum[FW-1:0];
    assign w_dn_val = (w_diff[FW] || (w_diff[FW-1:0] < r_cfg_start)) ? r_cfg_start
                                                                     : w_diff[FW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cfg_start <= '0;
            r_cfg_stop  <= '0;
            r_cfg_step  <= c_STEP_ONE;
            r_cfg_dwell <= '0;
            r_cfg_mode  <= c_MODE_SINGLE;
            r_cfg_err   <= 1'b0;
        end else begin
            r_cfg_err <= w_xfer && w_cfg_bad;
            if (w_cfg_take) begin
                r_cfg_start <= cfg_start;
                r_cfg_stop  <= cfg_stop;
                r_cfg_step  <= (cfg_step == '0) ? c_STEP_ONE : cfg_step;
                r_cfg_dwell <= cfg_dwell;
                r_cfg_mode  <= cfg_mode;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_freq_nxt  = r_freq;
        w_dir_nxt   = r_dir_up;
        w_cnt_nxt   = r_cnt;
        w_busy_nxt  = r_busy;
        w_tick_nxt  = 1'b0;
        w_done_nxt  = 1'b0;

        if (abort) begin
            w_state_nxt = c_ST_IDLE;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        w_freq_nxt  = w_eff_start;
                        w_busy_nxt  = 1'b1;
                        w_tick_nxt  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_dir_nxt   = 1'b1;
                        w_state_nxt = c_ST_DWELL;
                    end
                end
                c_ST_DWELL: begin
                    w_cnt_nxt = r_cnt + DWW'(1);
                    if (r_cnt == r_cfg_dwell) begin
                        w_state_nxt = c_ST_ADV;
                    end
                end
                c_ST_ADV: begin
                    w_tick_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_ST_DWELL;
                    if (r_dir_up) begin
                        if (r_freq < r_cfg_stop) begin
                            w_freq_nxt = w_up_val;
                        end else if (r_cfg_mode == c_MODE_REPEAT) begin
                            w_freq_nxt = r_cfg_start;
                        end else if (r_cfg_mode == c_MODE_TRI) begin
                            w_dir_nxt  = 1'b0;
                            w_freq_nxt = w_dn_val;
                        end else begin
                            w_tick_nxt  = 1'b0;
                            w_done_nxt  = 1'b1;
                            w_state_nxt = c_ST_FIN;
                        end
                    end else if (r_freq > r_cfg_start) begin
                        w_freq_nxt = w_dn_val;
                    end else begin
                        w_dir_nxt  = 1'b1;
                        w_freq_nxt = w_up_val;
                    end
                end
                default: begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_freq      <= '0;
            r_dir_up    <= 1'b1;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_step_tick <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_freq      <= w_freq_nxt;
            r_dir_up    <= w_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_busy      <= w_busy_nxt;
            r_step_tick <= w_tick_nxt;
            r_done      <= w_done_nxt;
        end
    end

endmodule
`default_nettype wire
